// File: rtl/csi_rx_byte_align_pkg.sv
// Shared types and helpers for the CSI-2 lane byte aligner.
// Used by csi_rx_sync_detect and csi_rx_byte_align.
package csi_rx_byte_align_pkg;

    localparam logic [7:0] CSI_SYNC_BYTE = 8'hB8;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } align_state_t;

    // True when a and b differ in at most one bit position.
    function automatic logic within_one_bit(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] diff;
        diff = a ^ b;
        return (diff & (diff - 8'd1)) == 8'd0;
    endfunction

endpackage

// File: rtl/csi_rx_sync_detect.sv
// Combinational sync-byte search over the 8 bit offsets of a 16-bit window.
// With CSI_RX_SYNC_1BIT_TOL_EN defined, a 1-bit-error candidate also hits; exact hits still win.
module csi_rx_sync_detect
    import csi_rx_byte_align_pkg::*;
(
    input  logic [15:0] window,
    input  logic [7:0]  pattern,
    output logic        hit,
    output logic        exact,
    output logic [2:0]  offset
);

    logic [7:0] exact_vec;
    logic [7:0] near_vec;
    logic       exact_any;
    logic       near_any;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_cand
            assign exact_vec[gi] = (window[gi+7:gi] == pattern);
`ifdef CSI_RX_SYNC_1BIT_TOL_EN
            assign near_vec[gi] = within_one_bit(window[gi+7:gi], pattern);
`else
            assign near_vec[gi] = exact_vec[gi];
`endif
        end
    endgenerate

    assign exact_any = |exact_vec;
    assign near_any  = |near_vec;

    // Exact matches anywhere outrank tolerant ones; within a class the lowest offset wins.
    always_comb begin
        offset = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (exact_any ? exact_vec[i] : near_vec[i]) begin
                offset = 3'(i);
            end
        end
        hit   = exact_any | near_any;
        exact = exact_any;
    end

endmodule

// File: rtl/csi_rx_byte_align.sv
// Byte aligner for one CSI-2 D-PHY lane: finds the HS sync byte, locks its bit offset, emits payload.
// Optional macro CSI_RX_SYNC_1BIT_TOL_EN enables locking on a sync byte with one bit in error.
module csi_rx_byte_align
    import csi_rx_byte_align_pkg::*;
#(
    parameter logic [7:0]  SYNC_PATTERN   = CSI_SYNC_BYTE,
    parameter logic [15:0] SEARCH_TIMEOUT = 16'd0
) (
    input  logic       byte_clock,
    input  logic       reset,
    input  logic [7:0] byte_in,
    input  logic       wait_for_sync,
    input  logic       packet_done,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    output logic [2:0] sync_offset,
    output logic       sync_timeout,
    output logic       sync_soft_err
);

    align_state_t state_reg, state_next;
    logic [7:0]   b0_reg, b1_reg;
    logic [15:0]  window;
    logic [15:0]  window_shifted;
    logic [7:0]   byte_out_reg, byte_out_next;
    logic         byte_valid_reg, byte_valid_next;
    logic [2:0]   sync_offset_reg, sync_offset_next;
    logic         sync_timeout_reg, sync_timeout_next;
    logic         soft_err_reg, soft_err_next;
    logic [15:0]  timeout_cnt_reg, timeout_cnt_next;
    logic         det_hit, det_exact, det_valid;
    logic [2:0]   det_offset;

    // Older word sits in the low byte because bit 0 is the oldest bit on the wire.
    assign window         = {b0_reg, b1_reg};
    assign window_shifted = window >> sync_offset_reg;
    assign det_valid      = wait_for_sync && det_hit;

    csi_rx_sync_detect u_sync_detect (
        .window  (window),
        .pattern (SYNC_PATTERN),
        .hit     (det_hit),
        .exact   (det_exact),
        .offset  (det_offset)
    );

    always_comb begin
        state_next        = state_reg;
        byte_out_next     = byte_out_reg;
        byte_valid_next   = 1'b0;
        sync_offset_next  = sync_offset_reg;
        sync_timeout_next = 1'b0;
        soft_err_next     = 1'b0;
        timeout_cnt_next  = timeout_cnt_reg;
        case (state_reg)
            SEARCH: begin
                if (det_valid && !packet_done) begin
                    state_next       = LOCKED;
                    sync_offset_next = det_offset;
                    soft_err_next    = !det_exact;
                end
                if (!wait_for_sync || det_valid) begin
                    timeout_cnt_next = 16'd0;
                end else if (SEARCH_TIMEOUT != 16'd0 && timeout_cnt_reg != SEARCH_TIMEOUT) begin
                    timeout_cnt_next  = timeout_cnt_reg + 16'd1;
                    sync_timeout_next = (timeout_cnt_reg + 16'd1 == SEARCH_TIMEOUT);
                end
            end
            LOCKED: begin
                timeout_cnt_next = 16'd0;
                if (packet_done) begin
                    state_next = SEARCH;
                end else begin
                    byte_out_next   = window_shifted[7:0];
                    byte_valid_next = 1'b1;
                end
            end
            default: begin
                state_next = SEARCH;
            end
        endcase
    end

    always_ff @(posedge byte_clock) begin
        if (reset) begin
            state_reg        <= SEARCH;
            b0_reg           <= 8'd0;
            b1_reg           <= 8'd0;
            byte_out_reg     <= 8'd0;
            byte_valid_reg   <= 1'b0;
            sync_offset_reg  <= 3'd0;
            sync_timeout_reg <= 1'b0;
            soft_err_reg     <= 1'b0;
            timeout_cnt_reg  <= 16'd0;
        end else begin
            state_reg        <= state_next;
            b0_reg           <= byte_in;
            b1_reg           <= b0_reg;
            byte_out_reg     <= byte_out_next;
            byte_valid_reg   <= byte_valid_next;
            sync_offset_reg  <= sync_offset_next;
            sync_timeout_reg <= sync_timeout_next;
            soft_err_reg     <= soft_err_next;
            timeout_cnt_reg  <= timeout_cnt_next;
        end
    end

    assign byte_out      = byte_out_reg;
    assign byte_valid    = byte_valid_reg;
    assign sync_offset   = sync_offset_reg;
    assign sync_timeout  = sync_timeout_reg;
    // Without tolerance every hit is exact, so this pulse can only fire when the macro is defined.
    assign sync_soft_err = soft_err_reg;

endmodule
